// File: rtl/sdes_engine_ctrl_pkg.sv
// S-DES package: FSM state type, S-box lookup constants and the fixed permutation helpers.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
// Bit order everywhere: the MSB of a vector is S-DES bit 1 (key bit 9 / data bit 7).
package sdes_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYGEN = 3'd1,
      ROUND1 = 3'd2,
      ROUND2 = 3'd3,
      DONE   = 3'd4
   } state_t;

   // S-boxes indexed by {row, col}; row = {in bit 1, in bit 4}, col = {in bit 2, in bit 3}.
   localparam logic [1:0] S0_LUT [16] = '{
      2'd1, 2'd0, 2'd3, 2'd2,
      2'd3, 2'd2, 2'd1, 2'd0,
      2'd0, 2'd2, 2'd1, 2'd3,
      2'd3, 2'd1, 2'd3, 2'd2
   };
   localparam logic [1:0] S1_LUT [16] = '{
      2'd0, 2'd1, 2'd2, 2'd3,
      2'd2, 2'd0, 2'd1, 2'd3,
      2'd3, 2'd0, 2'd1, 2'd0,
      2'd2, 2'd1, 2'd0, 2'd3
   };

   function automatic logic [9:0] p10(input logic [9:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   // Only key bits 3..10 are selected; bits 1 and 2 are dropped by the table.
   function automatic logic [7:0] p8(input logic [9:0] k);
      return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
   endfunction

   function automatic logic [3:0] p4(input logic [3:0] x);
      return {x[2], x[0], x[1], x[3]};
   endfunction

   function automatic logic [7:0] ep(input logic [3:0] r);
      return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
   endfunction

   function automatic logic [7:0] ip(input logic [7:0] d);
      return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
   endfunction

   function automatic logic [7:0] ip_inv(input logic [7:0] d);
      return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
   endfunction

   // Left rotate of each 5-bit key half by one and by two positions.
   function automatic logic [9:0] ls1(input logic [9:0] k);
      return {k[8:5], k[9], k[3:0], k[4]};
   endfunction

   function automatic logic [9:0] ls2(input logic [9:0] k);
      return {k[7:5], k[9:8], k[2:0], k[4:3]};
   endfunction

   function automatic logic [1:0] sbox0(input logic [3:0] x);
      return S0_LUT[{x[3], x[0], x[2], x[1]}];
   endfunction

   function automatic logic [1:0] sbox1(input logic [3:0] x);
      return S1_LUT[{x[3], x[0], x[2], x[1]}];
   endfunction

endpackage

// File: rtl/sdes_engine_ctrl_if.sv
// Request/response bundle between a host and the S-DES engine controller.
// Latency: n/a (wiring only).
// Backpressure: host may only start while o_ready is high; starts at other times are dropped.
// Ports: i_start/i_decrypt/i_key/i_data from host; o_ready/o_busy/o_valid/o_data from engine.
interface sdes_engine_ctrl_if;
   logic       i_start;
   logic       i_decrypt;
   logic [9:0] i_key;
   logic [7:0] i_data;
   logic       o_ready;
   logic       o_busy;
   logic       o_valid;
   logic [7:0] o_data;

   modport master (
      output i_start, i_decrypt, i_key, i_data,
      input  o_ready, o_busy, o_valid, o_data
   );

   modport slave (
      input  i_start, i_decrypt, i_key, i_data,
      output o_ready, o_busy, o_valid, o_data
   );
endinterface

// File: rtl/sdes_engine_ctrl_fk.sv
// S-DES round function fk: {L ^ P4(S0S1(EP(R) ^ K)), R}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: state_in (8b L|R), subkey (8b), state_out (8b).
module sdes_fk
   import sdes_pkg::*;
(
   input  logic [7:0] state_in,
   input  logic [7:0] subkey,
   output logic [7:0] state_out
);
   logic [7:0] mix;
   logic [3:0] f_out;

   assign mix       = ep(state_in[3:0]) ^ subkey;
   assign f_out     = p4({sbox0(mix[7:4]), sbox1(mix[3:0])});
   assign state_out = {state_in[7:4] ^ f_out, state_in[3:0]};
endmodule

// File: rtl/sdes_engine_ctrl.sv
// Iterative S-DES encrypt/decrypt controller: capture, key schedule, two shared fk rounds.
// Latency: o_valid in the cycle after the third edge following the start edge; 5 cycles/block max.
// Backpressure: i_start honoured only in IDLE (o_ready); otherwise dropped, never queued.
// Ports: i_clk, i_rst (sync, active high), bus (slave side of sdes_engine_ctrl_if).
module sdes_engine_ctrl
   import sdes_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   sdes_engine_ctrl_if.slave  bus
);
   state_t     state_q, state_nxt;
   logic [9:0] key_q;
   logic [7:0] data_q;
   logic       decrypt_q;
   logic [7:0] k1_q, k2_q;
   logic [7:0] blk_q;
   logic [7:0] out_q;
   logic [7:0] fk_key;
   logic [7:0] fk_out;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (bus.i_start) state_nxt = KEYGEN;
         KEYGEN:  state_nxt = ROUND1;
         ROUND1:  state_nxt = ROUND2;
         ROUND2:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the registered state only.
   always_comb begin
      bus.o_ready = 1'b0;
      bus.o_busy  = 1'b0;
      bus.o_valid = 1'b0;
      case (state_q)
         IDLE:                   bus.o_ready = 1'b1;
         KEYGEN, ROUND1, ROUND2: bus.o_busy  = 1'b1;
         DONE:                   bus.o_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.o_data = out_q;

   // Encrypt uses K1 then K2; decrypt reverses the order. Selecting K2 is
   // therefore "second round XOR decrypt".
   assign fk_key = ((state_q == ROUND2) ^ decrypt_q) ? k2_q : k1_q;

   sdes_fk u_fk (
      .state_in  (blk_q),
      .subkey    (fk_key),
      .state_out (fk_out)
   );

   // Datapath: one register update per state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         key_q     <= '0;
         data_q    <= '0;
         decrypt_q <= 1'b0;
         k1_q      <= '0;
         k2_q      <= '0;
         blk_q     <= '0;
         out_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_start) begin
                  key_q     <= bus.i_key;
                  data_q    <= bus.i_data;
                  decrypt_q <= bus.i_decrypt;
               end
            end
            KEYGEN: begin
               // LS3 is LS1 followed by LS2 on each half.
               k1_q  <= p8(ls1(p10(key_q)));
               k2_q  <= p8(ls2(ls1(p10(key_q))));
               blk_q <= ip(data_q);
            end
            ROUND1: blk_q <= {fk_out[3:0], fk_out[7:4]};
            ROUND2: out_q <= ip_inv(fk_out);
            default: ;
         endcase
      end
   end
endmodule
